serial_complementer: RTL and testbench
======================================

# serial_complementer

Parametrised, bit-serial one's/two's complement engine. Accepts a WIDTH-bit word on a start strobe and processes it LSB-first, one bit per clock. Two's complement uses the copy-until-first-one-then-invert rule. Provides a serial output stream, a parallel result, and carry-out/overflow flags. Sits beside the existing combinational complement logic as the sequential, width-generic successor for datapaths that stream operands serially.

## Interface
- WIDTH, 8, operand width in bits; legal range 2..32
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset, sampled on rising edge of clk
- start  input  1  request to begin an operation; honoured only when not busy
- mode  input  1  0 = one's complement, 1 = two's complement; sampled with start
- din  input  WIDTH  operand; sampled with start
- busy  output  1  high while bits are being processed
- sout  output  1  current result bit, LSB first
- sout_valid  output  1  qualifies sout
- dout  output  WIDTH  parallel result; held stable from done until next accepted start
- done  output  1  single-cycle completion pulse
- cout  output  1  two's mode: carry out of the +1 (operand was zero); 0 in one's mode
- ovf  output  1  two's mode: operand was most-negative (1 followed by WIDTH-1 zeros); 0 in one's mode

## Operation
- States: IDLE, SHIFT, DONE (enum in package).
- IDLE or DONE with start=1:
  - latch din into shift register, latch mode;
  - clear seen_one;
  - bit counter = 0;
  - go to SHIFT.
- start is ignored in SHIFT, with no effect and no queuing.
- SHIFT, per cycle, with b = shift register LSB:
  - One's mode: r = ~b.
  - Two's mode: r = seen_one ? ~b : b, then seen_one |= b.
  - Drive sout = r and sout_valid = 1.
  - Shift r into the result register from the MSB side, so after WIDTH shifts dout[i] holds bit i.
- At counter == WIDTH-1 (MSB step):
  - ovf = mode & ~seen_one & b, using seen_one before the update;
  - cout = mode & ~seen_one & ~b;
  - go to DONE.
- DONE: done = 1 for exactly this cycle; busy = 0. Go to IDLE, or to SHIFT if start = 1 (back-to-back).
- dout, cout and ovf update only at completion. They hold their values through IDLE and through the next operation until its completion.
- Reset values: state IDLE; busy, sout, sout_valid, done, cout, ovf = 0; dout = 0; counter = 0.
- Reset mid-operation aborts it. The next cycle shows the reset values, and a partial result is never reported.
- Counter width is $clog2(WIDTH). No arithmetic wider than 1 bit beyond the counter.

## Timing
- start accepted at edge k. Edges k+1..k+WIDTH are the SHIFT cycles, with sout_valid high exactly WIDTH consecutive cycles.
- done, dout, cout and ovf are visible in the cycle after the last sout_valid cycle. Latency from start edge to done is WIDTH+1 cycles.
- busy is high exactly during SHIFT cycles.
- Throughput: one word per WIDTH+1 cycles with start held or re-asserted in DONE.
- sout, sout_valid and done are registered outputs; there is no combinational path from inputs to outputs.
- Simultaneous rst_n = 0 and start = 1: reset wins.

## Structure
- Package serial_comp_pkg:
  - state_t enum {IDLE, SHIFT, DONE};
  - constants MODE_ONES = 1'b0 and MODE_TWOS = 1'b1.
- Sub-module comp_bit_cell: combinational per-bit rule (inputs b, mode, seen_one; outputs r, seen_one_next). Instantiated once in the datapath.
- Top holds the FSM, counter, shift and result registers, and the flag logic.

## Test plan
- WIDTH=8, two's, din=8'h06 → sout sequence LSB-first 0,1,0,1,1,1,1,1. dout=8'hFA, cout=0, ovf=0, done 9 cycles after start.
- WIDTH=8, one's, din=8'hA5 → dout=8'h5A, cout=0, ovf=0. Then two's, din=8'h00 → dout=8'h00, cout=1, ovf=0.
- WIDTH=8, two's, din=8'h80 → dout=8'h80, ovf=1, cout=0. WIDTH=3 exhaustive sweep of both modes: e.g. 3'b011 → two's 3'b101, one's 3'b100; all 16 results checked against a model.
- Back-to-back: start held high through DONE with din=8'h01 then 8'h02 → results 8'hFF then 8'hFE. Second op's sout_valid begins the cycle after the first done, and start pulses during SHIFT are ignored.
- Reset: rst_n=0 on the 4th SHIFT cycle → next cycle shows state IDLE, busy=0, sout_valid=0, done=0, dout=0. A fresh start then completes normally.

Source files
------------

// File: rtl/serial_complementer_pkg.sv
// Shared types and constants for the bit-serial complement engine.
package serial_comp_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic MODE_ONES = 1'b0;
    localparam logic MODE_TWOS = 1'b1;

endpackage

// File: rtl/serial_complementer_if.sv
// Handshake and data bundle between a requester and the serial complementer.
interface serial_complementer_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             mode;
    logic [WIDTH-1:0] din;
    logic             busy;
    logic             sout;
    logic             sout_valid;
    logic [WIDTH-1:0] dout;
    logic             done;
    logic             cout;
    logic             ovf;

    modport master (
        output start, mode, din,
        input  busy, sout, sout_valid, dout, done, cout, ovf
    );

    modport slave (
        input  start, mode, din,
        output busy, sout, sout_valid, dout, done, cout, ovf
    );
endinterface

// File: rtl/serial_complementer_bit_cell.sv
// Per-bit complement rule: invert always (one's) or copy until the first one, then invert (two's).
module comp_bit_cell
    import serial_comp_pkg::*;
(
    input  logic b,
    input  logic mode,
    input  logic seen_one,
    output logic r,
    output logic seen_one_next
);

    always_comb begin
        r             = ~b;
        seen_one_next = seen_one;
        if (mode == MODE_TWOS) begin
            r             = seen_one ? ~b : b;
            seen_one_next = seen_one | b;
        end
    end

endmodule

// File: rtl/serial_complementer.sv
// Bit-serial one's/two's complement engine: LSB-first stream plus parallel result and flags.
// Outputs are registered one stage behind the FSM, so results and done surface the cycle after the last stream bit.
module serial_complementer
    import serial_comp_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    serial_complementer_if.slave  bus
);

    localparam int              CW   = $clog2(WIDTH);
    localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shift_q;
    logic [WIDTH-1:0] res_q;
    logic [WIDTH-1:0] dout_q;
    logic [CW-1:0]    cnt_q;
    logic             mode_q;
    logic             seen_q;
    logic             cout_p_q, ovf_p_q;
    logic             cout_q, ovf_q;
    logic             sout_q, sout_valid_q, busy_q, done_q;
    logic             accept;
    logic             r_bit, seen_next;

    comp_bit_cell u_cell (
        .b             (shift_q[0]),
        .mode          (mode_q),
        .seen_one      (seen_q),
        .r             (r_bit),
        .seen_one_next (seen_next)
    );

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    accept  = 1'b1;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (cnt_q == LAST) state_d = DONE;
            end
            DONE: begin
                if (bus.start) begin
                    accept  = 1'b1;
                    state_d = SHIFT;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            shift_q      <= '0;
            res_q        <= '0;
            dout_q       <= '0;
            cnt_q        <= '0;
            mode_q       <= MODE_ONES;
            seen_q       <= 1'b0;
            cout_p_q     <= 1'b0;
            ovf_p_q      <= 1'b0;
            cout_q       <= 1'b0;
            ovf_q        <= 1'b0;
            sout_q       <= 1'b0;
            sout_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            sout_valid_q <= (state_q == SHIFT);
            busy_q       <= (state_q == SHIFT);
            sout_q       <= (state_q == SHIFT) ? r_bit : 1'b0;
            done_q       <= (state_q == DONE);

            if (accept) begin
                shift_q <= bus.din;
                mode_q  <= bus.mode;
                seen_q  <= 1'b0;
                cnt_q   <= '0;
            end else if (state_q == SHIFT) begin
                shift_q <= shift_q >> 1;
                res_q   <= {r_bit, res_q[WIDTH-1:1]};
                seen_q  <= seen_next;
                cnt_q   <= cnt_q + CW'(1);
                // Flags use seen_one as it stood before the MSB was consumed.
                if (cnt_q == LAST) begin
                    cout_p_q <= mode_q & ~seen_q & ~shift_q[0];
                    ovf_p_q  <= mode_q & ~seen_q &  shift_q[0];
                end
            end

            if (state_q == DONE) begin
                dout_q <= res_q;
                cout_q <= cout_p_q;
                ovf_q  <= ovf_p_q;
            end
        end
    end

    assign bus.busy       = busy_q;
    assign bus.sout       = sout_q;
    assign bus.sout_valid = sout_valid_q;
    assign bus.dout       = dout_q;
    assign bus.done       = done_q;
    assign bus.cout       = cout_q;
    assign bus.ovf        = ovf_q;

endmodule

// File: tb/tb_serial_complementer.sv
// Directed bench for serial_complementer at WIDTH=8 and an exhaustive WIDTH=3 sweep.
module tb_serial_complementer;
    import serial_comp_pkg::*;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    serial_complementer_if #(.WIDTH(8)) bus8 ();
    serial_complementer_if #(.WIDTH(3)) bus3 ();

    serial_complementer #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));
    serial_complementer #(.WIDTH(3)) dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic run8(input logic m, input logic [7:0] d, input logic [7:0] exp_dout,
                        input logic exp_cout, input logic exp_ovf, input string tag);
        logic [7:0] stream;
        int         nvalid;
        int         done_at;
        bus8.start = 1'b1;
        bus8.mode  = m;
        bus8.din   = d;
        @(posedge clk); #1;
        bus8.start = 1'b0;
        stream  = '0;
        nvalid  = 0;
        done_at = 0;
        for (int c = 1; c <= 20 && done_at == 0; c++) begin
            @(posedge clk); #1;
            if (bus8.sout_valid) begin
                stream = {bus8.sout, stream[7:1]};
                nvalid++;
            end
            if (bus8.done) done_at = c;
        end
        chk({tag, "_latency"}, 32'(done_at), 32'd9);
        chk({tag, "_nvalid"},  32'(nvalid),  32'd8);
        chk({tag, "_stream"},  32'(stream),  32'(exp_dout));
        chk({tag, "_dout"},    32'(bus8.dout), 32'(exp_dout));
        chk({tag, "_cout"},    32'(bus8.cout), 32'(exp_cout));
        chk({tag, "_ovf"},     32'(bus8.ovf),  32'(exp_ovf));
        @(posedge clk); #1;
        chk({tag, "_done_drop"}, 32'(bus8.done), 32'd0);
        chk({tag, "_dout_hold"}, 32'(bus8.dout), 32'(exp_dout));
    endtask

    task automatic run3(input logic m, input logic [2:0] x);
        logic [2:0] neg;
        logic [4:0] exp;
        int         done_at;
        neg = 3'd0 - x;
        exp = m ? {neg, (x == 3'd0), (x == 3'b100)} : {~x, 1'b0, 1'b0};
        bus3.start = 1'b1;
        bus3.mode  = m;
        bus3.din   = x;
        @(posedge clk); #1;
        bus3.start = 1'b0;
        done_at = 0;
        for (int c = 1; c <= 10 && done_at == 0; c++) begin
            @(posedge clk); #1;
            if (bus3.done) done_at = c;
        end
        chk($sformatf("w3_m%0d_x%0d", m, x), {27'd0, bus3.dout, bus3.cout, bus3.ovf}, {27'd0, exp});
        chk($sformatf("w3_m%0d_x%0d_lat", m, x), 32'(done_at), 32'd4);
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        rst_n      = 1'b0;
        bus8.start = 1'b0;
        bus8.mode  = 1'b0;
        bus8.din   = '0;
        bus3.start = 1'b0;
        bus3.mode  = 1'b0;
        bus3.din   = '0;
        // Start asserted during reset must be ignored.
        repeat (2) @(posedge clk);
        bus8.start = 1'b1;
        bus8.din   = 8'hFF;
        @(posedge clk); #1;
        bus8.start = 1'b0;
        chk("reset_outputs", {25'd0, bus8.busy, bus8.sout, bus8.sout_valid, bus8.done,
                              bus8.cout, bus8.ovf, 1'b0}, 32'd0);
        chk("reset_dout", 32'(bus8.dout), 32'd0);
        chk("reset_state", 32'(dut8.state_q), 32'(IDLE));
        rst_n = 1'b1;
        @(posedge clk); #1;

        run8(MODE_TWOS, 8'h06, 8'hFA, 1'b0, 1'b0, "twos_06");
        run8(MODE_ONES, 8'hA5, 8'h5A, 1'b0, 1'b0, "ones_A5");
        run8(MODE_TWOS, 8'h00, 8'h00, 1'b1, 1'b0, "twos_00");
        run8(MODE_TWOS, 8'h80, 8'h80, 1'b0, 1'b1, "twos_80");
        run8(MODE_ONES, 8'h00, 8'hFF, 1'b0, 1'b0, "ones_00");

        for (int m = 0; m < 2; m++)
            for (int x = 0; x < 8; x++)
                run3(1'(m), 3'(x));

        // Back-to-back with start held high; a changed din during SHIFT must not matter.
        bus8.start = 1'b1;
        bus8.mode  = MODE_TWOS;
        bus8.din   = 8'h01;
        @(posedge clk); #1;
        bus8.din = 8'h02;
        chk("b2b_busy_first", 32'(bus8.busy), 32'd0);
        for (int i = 1; i <= 9; i++) begin
            @(posedge clk); #1;
            if (i == 1) chk("b2b_busy_on", 32'(bus8.busy), 32'd1);
            if (i == 8) chk("b2b_done_early", 32'(bus8.done), 32'd0);
        end
        chk("b2b_done1", 32'(bus8.done), 32'd1);
        chk("b2b_dout1", 32'(bus8.dout), 32'hFF);
        chk("b2b_valid_gap", 32'(bus8.sout_valid), 32'd0);
        bus8.start = 1'b0;
        @(posedge clk); #1;
        chk("b2b_valid2_start", 32'(bus8.sout_valid), 32'd1);
        chk("b2b_dout1_hold", 32'(bus8.dout), 32'hFF);
        for (int i = 2; i <= 9; i++) begin
            if (i == 4) begin
                bus8.start = 1'b1;
                bus8.mode  = MODE_ONES;
                bus8.din   = 8'h55;
            end else begin
                bus8.start = 1'b0;
            end
            @(posedge clk); #1;
        end
        chk("b2b_done2", 32'(bus8.done), 32'd1);
        chk("b2b_dout2", 32'(bus8.dout), 32'hFE);
        @(posedge clk); #1;
        chk("b2b_no_queue", 32'(bus8.sout_valid), 32'd0);

        // Reset on the 4th SHIFT cycle.
        bus8.start = 1'b1;
        bus8.mode  = MODE_TWOS;
        bus8.din   = 8'h33;
        @(posedge clk); #1;
        bus8.start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("rst_mid_active", 32'(bus8.sout_valid), 32'd1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("rst_mid_state", 32'(dut8.state_q), 32'(IDLE));
        chk("rst_mid_flags", {28'd0, bus8.busy, bus8.sout_valid, bus8.done, bus8.sout}, 32'd0);
        chk("rst_mid_dout", 32'(bus8.dout), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        run8(MODE_TWOS, 8'h06, 8'hFA, 1'b0, 1'b0, "post_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
